id_ctrl: RTL



---
 rtl/id_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/id_ctrl.sv
// id_ctrl -- decode-stage controller for the 5-stage RISC-V pipeline.
//
// Owns the IF/ID register, decodes the held instruction into immediate
// select, register indices and memory/flow controls, stalls on load-use
// hazards and EX busy, honours redirect flushes and counts stall cycles.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   if_valid/if_inst/if_pc/if_ready   fetch handshake into IF/ID
//   flush             kill IF/ID contents (branch/jump redirect)
//   ex_busy           EX cannot accept this cycle
//   ex_mem_read/ex_rd load in ID/EX and its destination (hazard check)
//   id_issue          ID/EX captures decoded fields this cycle
//   id_inst/id_pc     held instruction and its PC
//   imm_sel           immediate-generator select (IMM_SEL_* codes)
//   rs1/rs2/rd        register indices, zeroed when unused
//   reg_wen..illegal  decoded controls, zeroed when ID holds a bubble
//   stall_cnt         saturating count of decode stall cycles

`ifndef INST_WIDTH
`define INST_WIDTH 32
`endif
`ifndef IMM_SEL_WIDTH
`define IMM_SEL_WIDTH 3
`endif
`ifndef IMM_SEL_I
`define IMM_SEL_I 3'd0
`define IMM_SEL_S 3'd1
`define IMM_SEL_B 3'd2
`define IMM_SEL_U 3'd3
`define IMM_SEL_J 3'd4
`endif

module id_ctrl #(
   parameter int INST_WIDTH     = `INST_WIDTH,
   parameter int PC_WIDTH       = 32,
   parameter int IMM_SEL_WIDTH  = `IMM_SEL_WIDTH,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      if_valid,
   input  logic [INST_WIDTH-1:0]     if_inst,
   input  logic [PC_WIDTH-1:0]       if_pc,
   output logic                      if_ready,
   input  logic                      flush,
   input  logic                      ex_busy,
   input  logic                      ex_mem_read,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
   output logic                      id_issue,
   output logic [INST_WIDTH-1:0]     id_inst,
   output logic [PC_WIDTH-1:0]       id_pc,
   output logic [IMM_SEL_WIDTH-1:0]  imm_sel,
   output logic [REG_ADDR_WIDTH-1:0] rs1,
   output logic [REG_ADDR_WIDTH-1:0] rs2,
   output logic [REG_ADDR_WIDTH-1:0] rd,
   output logic                      reg_wen,
   output logic                      mem_read,
   output logic                      mem_write,
   output logic                      branch,
   output logic                      jump,
   output logic                      u_type,
   output logic                      illegal,
   output logic [CNT_WIDTH-1:0]      stall_cnt
);

   localparam logic [INST_WIDTH-1:0]    NOP   = INST_WIDTH'(32'h0000_0013);
   localparam logic [IMM_SEL_WIDTH-1:0] SEL_I = IMM_SEL_WIDTH'(`IMM_SEL_I);
   localparam logic [IMM_SEL_WIDTH-1:0] SEL_S = IMM_SEL_WIDTH'(`IMM_SEL_S);
   localparam logic [IMM_SEL_WIDTH-1:0] SEL_B = IMM_SEL_WIDTH'(`IMM_SEL_B);
   localparam logic [IMM_SEL_WIDTH-1:0] SEL_J = IMM_SEL_WIDTH'(`IMM_SEL_J);

   typedef struct packed {
      logic [IMM_SEL_WIDTH-1:0] imm_sel;
      logic use_rs1;
      logic use_rs2;
      logic reg_wen;
      logic mem_read;
      logic mem_write;
      logic branch;
      logic jump;
      logic u_type;
      logic illegal;
   } dec_t;

   logic                      id_valid;
   dec_t                      dec;
   logic                      hz;
   logic [REG_ADDR_WIDTH-1:0] rs1_f, rs2_f, rd_f;

   assign rs1_f = REG_ADDR_WIDTH'(id_inst[19:15]);
   assign rs2_f = REG_ADDR_WIDTH'(id_inst[24:20]);
   assign rd_f  = REG_ADDR_WIDTH'(id_inst[11:7]);

   // Opcode decode; a bubble decodes to all-zero controls with imm_sel=I.
   always_comb begin
      dec         = '0;
      dec.imm_sel = SEL_I;
      if (id_valid) begin
         case (id_inst[6:0])
            7'b0010011: begin dec.reg_wen = 1'b1; dec.use_rs1 = 1'b1; end
            7'b0000011: begin
               dec.mem_read = 1'b1; dec.reg_wen = 1'b1; dec.use_rs1 = 1'b1;
            end
            7'b1100111: begin
               dec.jump = 1'b1; dec.reg_wen = 1'b1; dec.use_rs1 = 1'b1;
            end
            7'b0100011: begin
               dec.imm_sel = SEL_S; dec.mem_write = 1'b1;
               dec.use_rs1 = 1'b1;  dec.use_rs2   = 1'b1;
            end
            7'b1100011: begin
               dec.imm_sel = SEL_B; dec.branch  = 1'b1;
               dec.use_rs1 = 1'b1;  dec.use_rs2 = 1'b1;
            end
            7'b1101111: begin
               dec.imm_sel = SEL_J; dec.jump = 1'b1; dec.reg_wen = 1'b1;
            end
            7'b0110011: begin
               dec.reg_wen = 1'b1; dec.use_rs1 = 1'b1; dec.use_rs2 = 1'b1;
            end
            // LUI/AUIPC: datapath builds the upper immediate itself.
            7'b0110111,
            7'b0010111: begin dec.u_type = 1'b1; dec.reg_wen = 1'b1; end
            default:    dec.illegal = 1'b1;
         endcase
      end
   end

   // Load-use: the ID/EX load's result is not yet forwardable.
   assign hz = id_valid & ex_mem_read & (ex_rd != '0) &
               ((dec.use_rs1 & (rs1_f == ex_rd)) |
                (dec.use_rs2 & (rs2_f == ex_rd)));

   assign id_issue = id_valid & ~hz & ~ex_busy & ~flush;
   assign if_ready = flush | ~id_valid | id_issue;

   assign imm_sel   = dec.imm_sel;
   assign rs1       = dec.use_rs1 ? rs1_f : '0;
   assign rs2       = dec.use_rs2 ? rs2_f : '0;
   assign rd        = dec.reg_wen ? rd_f  : '0;
   assign reg_wen   = dec.reg_wen;
   assign mem_read  = dec.mem_read;
   assign mem_write = dec.mem_write;
   assign branch    = dec.branch;
   assign jump      = dec.jump;
   assign u_type    = dec.u_type;
   assign illegal   = dec.illegal;

   always_ff @(posedge clk) begin
      if (rst) begin
         id_valid  <= 1'b0;
         id_inst   <= NOP;
         id_pc     <= '0;
         stall_cnt <= '0;
      end else begin
         if (flush) begin
            id_valid <= 1'b0;
            id_inst  <= NOP;
         end else if (if_ready && if_valid) begin
            id_valid <= 1'b1;
            id_inst  <= if_inst;
            id_pc    <= if_pc;
         end else if (if_ready) begin
            id_valid <= 1'b0;
            id_inst  <= NOP;
         end
         // Counts held cycles only; a flush is a redirect, not a stall.
         if (id_valid && !id_issue && !flush && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule
